// File: rtl/framebuffer_blitter_pkg.sv
// ---------------------------------------------------------------------------
// blit_pkg
// Shared constants and types for the framebuffer blitter: framebuffer
// geometry, transparent colour key, address width, controller state
// encoding and the blit command record.
// ---------------------------------------------------------------------------
package blit_pkg;

   localparam int unsigned ADDR_W    = 19;          // RAM address width
   localparam int unsigned SRC_W     = 240;         // default source row pitch
   localparam int unsigned FB_W      = 240;         // framebuffer width
   localparam int unsigned FB_H      = 160;         // framebuffer height
   localparam logic [23:0] KEY_COLOR = 24'hFF00FF;  // transparent colour

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } blit_state_e;

   // One blit request. dst_x/dst_y are two's complement (may be negative).
   typedef struct packed {
      logic [9:0] src_x;
      logic [9:0] src_y;
      logic [9:0] dst_x;
      logic [9:0] dst_y;
      logic [7:0] w;
      logic [7:0] h;
      logic       key_en;
   } blit_cmd_t;

endpackage

// File: rtl/framebuffer_blitter_if.sv
// ---------------------------------------------------------------------------
// framebuffer_blitter_if
// Bundles the blitter's command handshake, source RAM read port,
// framebuffer write port and status flags.
//   slave  : the blitter itself (takes commands, drives both RAM ports)
//   master : the command issuer / memory environment around it
// ---------------------------------------------------------------------------
interface framebuffer_blitter_if;
   import blit_pkg::ADDR_W;

   // command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic [9:0]        cmd_src_x;
   logic [9:0]        cmd_src_y;
   logic [9:0]        cmd_dst_x;
   logic [9:0]        cmd_dst_y;
   logic [7:0]        cmd_w;
   logic [7:0]        cmd_h;
   logic              cmd_key_en;
   // source RAM (registered read, data one cycle after address)
   logic [ADDR_W-1:0] src_read_address;
   logic [23:0]       src_data;
   // framebuffer write port
   logic [ADDR_W-1:0] fb_write_address;
   logic [23:0]       fb_data_In;
   logic              fb_we;
   // status
   logic              busy;
   logic              done;

   modport slave (
      input  cmd_valid, cmd_src_x, cmd_src_y, cmd_dst_x, cmd_dst_y,
             cmd_w, cmd_h, cmd_key_en, src_data,
      output cmd_ready, src_read_address, fb_write_address, fb_data_In,
             fb_we, busy, done
   );

   modport master (
      output cmd_valid, cmd_src_x, cmd_src_y, cmd_dst_x, cmd_dst_y,
             cmd_w, cmd_h, cmd_key_en, src_data,
      input  cmd_ready, src_read_address, fb_write_address, fb_data_In,
             fb_we, busy, done
   );

endinterface

// File: rtl/framebuffer_blitter_addr_gen.sv
// ---------------------------------------------------------------------------
// blit_addr_gen
// Walks a w x h rectangle in raster order, one pixel per step, and produces
// the matching source RAM address. The source origin is folded into a row
// base register at start; each row wrap adds the row pitch, so the
// per-pixel path is adders only.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : load origin, clear col/row
//   step_i          : advance to the next pixel
//   src_x_i/src_y_i : source origin, sampled on start_i
//   w_i/h_i         : rectangle size (held stable while stepping)
//   col_o/row_o     : current pixel position inside the rectangle
//   last_o          : current pixel is (w-1, h-1)
//   src_addr_o      : source RAM address of the current pixel
// ---------------------------------------------------------------------------
module blit_addr_gen
   import blit_pkg::ADDR_W;
#(
   parameter int unsigned SRC_W = 240
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              step_i,
   input  logic [9:0]        src_x_i,
   input  logic [9:0]        src_y_i,
   input  logic [7:0]        w_i,
   input  logic [7:0]        h_i,
   output logic [7:0]        col_o,
   output logic [7:0]        row_o,
   output logic              last_o,
   output logic [ADDR_W-1:0] src_addr_o
);

   localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(SRC_W);

   logic [7:0]        col_q, col_d;
   logic [7:0]        row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;   // address of (src_x, src_y + row)
   logic              col_wrap;

   assign col_wrap = (col_q == w_i - 8'd1);

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      if (start_i) begin
         col_d  = 8'd0;
         row_d  = 8'd0;
         // Constant-coefficient product, evaluated once per command.
         base_d = ADDR_W'(src_y_i) * PITCH + ADDR_W'(src_x_i);
      end else if (step_i) begin
         if (col_wrap) begin
            col_d  = 8'd0;
            row_d  = row_q + 8'd1;
            base_d = base_q + PITCH;
         end else begin
            col_d  = col_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset as well so the read address
         // comes out of reset at a defined zero.
         col_q  <= 8'd0;
         row_q  <= 8'd0;
         base_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values and updates together.
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end

   assign col_o      = col_q;
   assign row_o      = row_q;
   assign last_o     = col_wrap && (row_q == h_i - 8'd1);
   assign src_addr_o = base_q + ADDR_W'(col_q);

endmodule

// File: rtl/framebuffer_blitter.sv
// ---------------------------------------------------------------------------
// framebuffer_blitter
// Copies a rectangle from the source sprite RAM into the framebuffer, one
// pixel per clock, clipping against the framebuffer edges and optionally
// dropping pixels equal to the colour key.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : command handshake, source read port, framebuffer write
//                  port, busy/done status
// Pipeline: RUN cycle k presents the read address of pixel k; the write
// stage registers that pixel's clip result and destination address and
// fires in cycle k+1, when the RAM data arrives.
// ---------------------------------------------------------------------------
module framebuffer_blitter #(
   parameter int unsigned SRC_W     = blit_pkg::SRC_W,
   parameter int unsigned FB_W      = blit_pkg::FB_W,
   parameter int unsigned FB_H      = blit_pkg::FB_H,
   parameter logic [23:0] KEY_COLOR = blit_pkg::KEY_COLOR
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   framebuffer_blitter_if.slave  bus
);
   import blit_pkg::ADDR_W, blit_pkg::blit_state_e, blit_pkg::blit_cmd_t;
   import blit_pkg::S_IDLE, blit_pkg::S_RUN, blit_pkg::S_DRAIN, blit_pkg::S_DONE;

   localparam logic signed [10:0]  FB_W_S = 11'(FB_W);
   localparam logic signed [10:0]  FB_H_S = 11'(FB_H);
   localparam logic [ADDR_W-1:0]   FB_W_A = ADDR_W'(FB_W);

   blit_state_e       state_q, state_d;
   blit_cmd_t         cmd_in;
   logic              accept, nonempty, start, step, last;

   // latched command fields used after acceptance
   logic [9:0]        dst_x_q, dst_y_q;
   logic [7:0]        w_q, h_q;
   logic              key_en_q;

   logic [7:0]        col, row;
   logic signed [10:0] dx_c, dy_c;
   logic              clip_c;
   logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
   logic              wr_valid_q, wr_clip_q;
   logic              key_hit;

   // ------------------------------------------------------------------
   // Command capture
   // ------------------------------------------------------------------
   always_comb begin
      cmd_in = '{src_x:  bus.cmd_src_x,
                 src_y:  bus.cmd_src_y,
                 dst_x:  bus.cmd_dst_x,
                 dst_y:  bus.cmd_dst_y,
                 w:      bus.cmd_w,
                 h:      bus.cmd_h,
                 key_en: bus.cmd_key_en};
   end

   // Commands arriving outside IDLE are simply not accepted.
   assign accept   = bus.cmd_valid && (state_q == S_IDLE);
   assign nonempty = (cmd_in.w != 8'd0) && (cmd_in.h != 8'd0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         dst_x_q  <= '0;
         dst_y_q  <= '0;
         w_q      <= '0;
         h_q      <= '0;
         key_en_q <= 1'b0;
      end else if (accept) begin
         dst_x_q  <= cmd_in.dst_x;
         dst_y_q  <= cmd_in.dst_y;
         w_q      <= cmd_in.w;
         h_q      <= cmd_in.h;
         key_en_q <= cmd_in.key_en;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = nonempty ? S_RUN : S_DONE;
         S_RUN:   if (last)   state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      start         = 1'b0;
      step          = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            start         = bus.cmd_valid && nonempty;
         end
         S_RUN: begin
            bus.busy = 1'b1;
            step     = 1'b1;
         end
         S_DRAIN: bus.busy = 1'b1;
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Source address generation
   // ------------------------------------------------------------------
   blit_addr_gen #(
      .SRC_W (SRC_W)
   ) u_addr_gen (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .start_i    (start),
      .step_i     (step),
      .src_x_i    (cmd_in.src_x),
      .src_y_i    (cmd_in.src_y),
      .w_i        (w_q),
      .h_i        (h_q),
      .col_o      (col),
      .row_o      (row),
      .last_o     (last),
      .src_addr_o (bus.src_read_address)
   );

   // ------------------------------------------------------------------
   // Clip and destination address for the pixel being read this cycle.
   // Sums are 11-bit signed so a negative origin plus a column offset
   // cannot wrap into the visible range.
   // ------------------------------------------------------------------
   always_comb begin
      dx_c      = $signed({dst_x_q[9], dst_x_q}) + $signed({3'b000, col});
      dy_c      = $signed({dst_y_q[9], dst_y_q}) + $signed({3'b000, row});
      clip_c    = !dx_c[10] && (dx_c < FB_W_S) && !dy_c[10] && (dy_c < FB_H_S);
      // Only meaningful when clip_c is set; out-of-range values are never
      // written.
      wr_addr_d = ADDR_W'($unsigned(dy_c)) * FB_W_A + ADDR_W'($unsigned(dx_c));
   end

   // Write stage: one-cycle delayed copy, aligned with the RAM read data.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_valid_q <= 1'b0;
         wr_clip_q  <= 1'b0;
         wr_addr_q  <= '0;
      end else begin
         wr_valid_q <= step;
         wr_clip_q  <= clip_c;
         wr_addr_q  <= wr_addr_d;
      end
   end

   assign key_hit          = key_en_q && (bus.src_data == KEY_COLOR);
   assign bus.fb_we        = wr_valid_q && wr_clip_q && !key_hit;
   assign bus.fb_write_address = wr_addr_q;
   // Gated so the write data reads zero whenever no pixel is in flight.
   assign bus.fb_data_In   = wr_valid_q ? bus.src_data : 24'd0;

endmodule
